cpu_slot_arb: RTL and testbench

CPU_SLOT_ARB -- requirements
Module: cpu_slot_arb

---
 rtl/cpu_arb_pkg.sv | 39 +++
 rtl/cpu_arb_next.sv | 21 ++
 rtl/cpu_slot_arb.sv | 135 +++++++++++++
 tb/tb_cpu_slot_arb.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_arb_pkg.sv
// Shared definitions for the CPU slot arbiter: mode encodings and the
// round-robin owner search used by the compacting scheduler.
package cpu_arb_pkg;

  localparam int MODE_TDM     = 0;
  localparam int MODE_COMPACT = 1;
  localparam int MAX_CPU      = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First channel with hold low, searching start, start+1, ... modulo ncpu.
  function automatic pick_t next_owner(input logic [7:0] hold,
                                       input logic [2:0] start,
                                       input int         ncpu);
    pick_t      p;
    logic [3:0] c;
    p = '0;
    // Descending walk so the closest candidate to start is written last.
    for (int i = MAX_CPU - 1; i >= 0; i--) begin
      if (i < ncpu) begin
        c = {1'b0, start} + 4'(i);
        if (c >= 4'(ncpu)) c = c - 4'(ncpu);
        if (!hold[c[2:0]]) begin
          p.found = 1'b1;
          p.idx   = c[2:0];
        end
      end
    end
    return p;
  endfunction

  function automatic logic [2:0] wrap_inc(input logic [2:0] idx, input int ncpu);
    return (({1'b0, idx} + 4'd1) >= 4'(ncpu)) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/cpu_arb_next.sv
// Combinational round-robin finder: next channel with HOLD low from start.
module cpu_arb_next
  import cpu_arb_pkg::*;
#(
  parameter int NCPU = 3
) (
  input  logic [7:0] hold,
  input  logic [2:0] start,
  output logic       found,
  output logic [2:0] idx
);

  pick_t pick;

  always_comb begin
    pick  = next_owner(hold, start, NCPU);
    found = pick.found;
    idx   = pick.idx;
  end

endmodule

// File: rtl/cpu_slot_arb.sv
// Time-slot arbiter sharing one device bus among NCPU CPUs, with a fixed
// TDM rotation or a compacting round-robin that skips held channels.
module cpu_slot_arb
  import cpu_arb_pkg::*;
#(
  parameter int NCPU     = 3,
  parameter int NSLOT    = 4,
  parameter int SLOT_LEN = 4,
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int MODE     = 0
) (
  input  logic                 MCLK,
  input  logic                 RESET,
  input  logic [NCPU-1:0]      HOLD,
  output logic [NCPU-1:0]      CPU_CE,
  input  logic [NCPU*AW-1:0]   CPU_AD,
  input  logic [NCPU-1:0]      CPU_RD,
  input  logic [NCPU-1:0]      CPU_WR,
  input  logic [NCPU*DW-1:0]   CPU_DO,
  output logic [NCPU-1:0]      CPU_DV,
  output logic [NCPU*DW-1:0]   CPU_DI,
  output logic [AW-1:0]        DEV_AD,
  output logic                 DEV_RD,
  output logic                 DEV_WR,
  output logic [DW-1:0]        DEV_DI,
  input  logic                 DEV_DV,
  input  logic [DW-1:0]        DEV_DO,
  output logic                 DEV_STB,
  output logic [2:0]           OWNER,
  output logic                 BUSY
);

  localparam int             PW        = $clog2(SLOT_LEN);
  localparam logic [PW-1:0]  PH_LAST   = PW'(SLOT_LEN - 1);
  localparam logic [3:0]     NCPU4     = 4'(NCPU);
  localparam logic [2:0]     SLOT_LAST = 3'(NSLOT - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    slot_q, slot_d;
  logic [2:0]    base_q, base_d;
  logic          busy_q, busy_d;

  logic [7:0]    hold_ext;
  logic          nxt_found;
  logic [2:0]    nxt_idx;
  logic          at_p0, at_last;
  logic [2:0]    cur_slot;
  logic          cur_grant;

  // Unused channel positions read as held so they can never be picked.
  always_comb begin
    hold_ext           = '1;
    hold_ext[NCPU-1:0] = HOLD;
  end

  cpu_arb_next #(.NCPU(NCPU)) u_next (
    .hold  (hold_ext),
    .start (base_q),
    .found (nxt_found),
    .idx   (nxt_idx)
  );

  assign at_p0   = (phase_q == '0);
  assign at_last = (phase_q == PH_LAST);

  // Grant decision is live at phase 0 and frozen in busy_q for the rest of the slot.
  always_comb begin
    cur_slot  = slot_q;
    cur_grant = busy_q;
    if (at_p0) begin
      if (MODE == MODE_COMPACT) begin
        cur_grant = nxt_found;
        if (nxt_found) cur_slot = nxt_idx;
      end else begin
        cur_grant = ({1'b0, slot_q} < NCPU4) && !hold_ext[slot_q];
      end
    end
    if (RESET) begin
      cur_slot  = '0;
      cur_grant = 1'b0;
    end
  end

  always_comb begin
    phase_d = at_last ? '0 : phase_q + 1'b1;
    slot_d  = cur_slot;
    busy_d  = cur_grant;
    base_d  = base_q;
    if (MODE == MODE_COMPACT) begin
      if (at_p0 && nxt_found) base_d = wrap_inc(nxt_idx, NCPU);
    end else if (at_last) begin
      slot_d = (slot_q == SLOT_LAST) ? 3'd0 : slot_q + 3'd1;
    end
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      phase_q <= '0;
      slot_q  <= '0;
      base_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      slot_q  <= slot_d;
      base_q  <= base_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    CPU_CE  = '0;
    CPU_DV  = '0;
    CPU_DI  = '0;
    DEV_AD  = '0;
    DEV_RD  = 1'b0;
    DEV_WR  = 1'b0;
    DEV_DI  = '0;
    DEV_STB = at_p0 && cur_grant;
    OWNER   = cur_slot;
    BUSY    = cur_grant;
    for (int i = 0; i < NCPU; i++) begin
      if (cur_grant && (cur_slot == 3'(i))) begin
        DEV_AD              = CPU_AD[i*AW +: AW];
        DEV_RD              = CPU_RD[i];
        DEV_WR              = CPU_WR[i];
        DEV_DI              = CPU_DO[i*DW +: DW];
        CPU_DV[i]           = DEV_DV;
        CPU_DI[i*DW +: DW]  = DEV_DO;
        CPU_CE[i]           = at_last;
      end
    end
  end

endmodule

// File: tb/tb_cpu_slot_arb.sv
// Bench for cpu_slot_arb: a TDM and a compacting instance share stimulus and
// are compared each cycle against a slot-schedule model, plus fixed timing points.
module tb_cpu_slot_arb;

  localparam int NCPU = 3, NSLOT = 4, SLOT_LEN = 4, AW = 16, DW = 8;

  logic                MCLK = 1'b0;
  logic                RESET = 1'b1;
  logic [NCPU-1:0]     HOLD = '0;
  logic [NCPU*AW-1:0]  CPU_AD = '0;
  logic [NCPU-1:0]     CPU_RD = '0;
  logic [NCPU-1:0]     CPU_WR = '0;
  logic [NCPU*DW-1:0]  CPU_DO = '0;
  logic                DEV_DV = 1'b0;
  logic [DW-1:0]       DEV_DO = '0;

  logic [NCPU-1:0]     ce0, dv0, ce1, dv1;
  logic [NCPU*DW-1:0]  di0, di1;
  logic [AW-1:0]       ad0, ad1;
  logic                rd0, wr0, stb0, busy0, rd1, wr1, stb1, busy1;
  logic [DW-1:0]       ddi0, ddi1;
  logic [2:0]          own0, own1;

  always #5 MCLK = ~MCLK;

  cpu_slot_arb #(.NCPU(NCPU), .NSLOT(NSLOT), .SLOT_LEN(SLOT_LEN), .AW(AW), .DW(DW), .MODE(0)) u_tdm (
    .MCLK(MCLK), .RESET(RESET), .HOLD(HOLD), .CPU_CE(ce0), .CPU_AD(CPU_AD), .CPU_RD(CPU_RD),
    .CPU_WR(CPU_WR), .CPU_DO(CPU_DO), .CPU_DV(dv0), .CPU_DI(di0), .DEV_AD(ad0), .DEV_RD(rd0),
    .DEV_WR(wr0), .DEV_DI(ddi0), .DEV_DV(DEV_DV), .DEV_DO(DEV_DO), .DEV_STB(stb0),
    .OWNER(own0), .BUSY(busy0));

  cpu_slot_arb #(.NCPU(NCPU), .NSLOT(NSLOT), .SLOT_LEN(SLOT_LEN), .AW(AW), .DW(DW), .MODE(1)) u_cmp (
    .MCLK(MCLK), .RESET(RESET), .HOLD(HOLD), .CPU_CE(ce1), .CPU_AD(CPU_AD), .CPU_RD(CPU_RD),
    .CPU_WR(CPU_WR), .CPU_DO(CPU_DO), .CPU_DV(dv1), .CPU_DI(di1), .DEV_AD(ad1), .DEV_RD(rd1),
    .DEV_WR(wr1), .DEV_DI(ddi1), .DEV_DV(DEV_DV), .DEV_DO(DEV_DO), .DEV_STB(stb1),
    .OWNER(own1), .BUSY(busy1));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input string p, input int ph, input bit g, input int o,
                           input logic [NCPU-1:0] ce, input logic stb, input logic [2:0] own,
                           input logic busy, input logic [AW-1:0] ad, input logic rd,
                           input logic wr, input logic [DW-1:0] ddi,
                           input logic [NCPU-1:0] dv, input logic [NCPU*DW-1:0] di);
    logic [NCPU-1:0]    e_ce, e_dv;
    logic [NCPU*DW-1:0] e_di;
    logic [AW-1:0]      e_ad;
    logic [DW-1:0]      e_ddi;
    logic               e_rd, e_wr;
    e_ce = '0; e_dv = '0; e_di = '0; e_ad = '0; e_ddi = '0; e_rd = 1'b0; e_wr = 1'b0;
    if (g) begin
      if (ph == SLOT_LEN - 1) e_ce[o] = 1'b1;
      e_ad              = CPU_AD[o*AW +: AW];
      e_rd              = CPU_RD[o];
      e_wr              = CPU_WR[o];
      e_ddi             = CPU_DO[o*DW +: DW];
      e_dv[o]           = DEV_DV;
      e_di[o*DW +: DW]  = DEV_DO;
    end
    chk({p, ".ce"},    64'(ce),   64'(e_ce));
    chk({p, ".stb"},   64'(stb),  64'(g && ph == 0));
    chk({p, ".owner"}, 64'(own),  64'(o));
    chk({p, ".busy"},  64'(busy), 64'(g));
    chk({p, ".dev_ad"}, 64'(ad),  64'(e_ad));
    chk({p, ".dev_rd"}, 64'(rd),  64'(e_rd));
    chk({p, ".dev_wr"}, 64'(wr),  64'(e_wr));
    chk({p, ".dev_di"}, 64'(ddi), 64'(e_ddi));
    chk({p, ".cpu_dv"}, 64'(dv),  64'(e_dv));
    chk({p, ".cpu_di"}, 64'(di),  64'(e_di));
  endtask

  // Reference schedule: TDM slot is a pure function of elapsed cycles;
  // compacting mode keeps a round-robin pointer updated once per slot.
  bit  chk_en = 1'b0;
  int  t = 0, o1 = 0, b1 = 0, ph, s0;
  bit  g0 = 1'b0, g1 = 1'b0;
  logic [NCPU-1:0]    ce0_log[64], ce1_log[64];
  logic [AW-1:0]      ad0_log[64];
  logic [NCPU*DW-1:0] di0_log[64];
  logic [NCPU-1:0]    acc_ce0 = '0, acc_ce1 = '0;

  always @(negedge MCLK) begin
    if (chk_en) begin
      if (RESET) begin
        check_dut("tdm_rst", 1, 1'b0, 0, ce0, stb0, own0, busy0, ad0, rd0, wr0, ddi0, dv0, di0);
        check_dut("cmp_rst", 1, 1'b0, 0, ce1, stb1, own1, busy1, ad1, rd1, wr1, ddi1, dv1, di1);
        t = 0; o1 = 0; b1 = 0; g0 = 1'b0; g1 = 1'b0;
        for (int k = 0; k < 64; k++) begin
          ce0_log[k] = '0; ce1_log[k] = '0; ad0_log[k] = '0; di0_log[k] = '0;
        end
      end else begin
        ph = t % SLOT_LEN;
        s0 = (t / SLOT_LEN) % NSLOT;
        if (ph == 0) begin
          g0 = (s0 < NCPU) && !HOLD[s0];
          g1 = 1'b0;
          for (int k = 0; k < NCPU; k++) begin
            if (!g1 && !HOLD[(b1 + k) % NCPU]) begin
              g1 = 1'b1;
              o1 = (b1 + k) % NCPU;
            end
          end
          if (g1) b1 = (o1 + 1) % NCPU;
        end
        check_dut("tdm", ph, g0, s0, ce0, stb0, own0, busy0, ad0, rd0, wr0, ddi0, dv0, di0);
        check_dut("cmp", ph, g1, o1, ce1, stb1, own1, busy1, ad1, rd1, wr1, ddi1, dv1, di1);
        if (t < 64) begin
          ce0_log[t] = ce0; ce1_log[t] = ce1; ad0_log[t] = ad0; di0_log[t] = di0;
        end
        acc_ce0 = acc_ce0 | ce0;
        acc_ce1 = acc_ce1 | ce1;
        t++;
      end
    end
  end

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    repeat (n) tick();
    RESET = 1'b0;
  endtask

  logic [NCPU-1:0] ce_or;

  initial begin
    tick();
    chk_en = 1'b1;

    // Free-running rotation, nothing held.
    HOLD = '0;
    do_reset(2);
    repeat (32) tick();
    chk("tdm_ce3",  64'(ce0_log[3]),  64'h1);
    chk("tdm_ce7",  64'(ce0_log[7]),  64'h2);
    chk("tdm_ce11", 64'(ce0_log[11]), 64'h4);
    chk("tdm_ce15", 64'(ce0_log[15]), 64'h0);
    chk("tdm_ce19", 64'(ce0_log[19]), 64'h1);
    chk("tdm_ce27", 64'(ce0_log[27]), 64'h4);
    chk("tdm_ce31", 64'(ce0_log[31]), 64'h0);
    chk("cmp_ce15", 64'(ce1_log[15]), 64'h1);

    // CPU1 read routed through its slot only.
    CPU_AD = '0;
    CPU_AD[1*AW +: AW] = 16'h6800;
    CPU_RD = 3'b010;
    DEV_DO = 8'h5A;
    DEV_DV = 1'b1;
    do_reset(2);
    repeat (12) tick();
    chk("rd_ad3", 64'(ad0_log[3]), 64'h0);
    chk("rd_ad4", 64'(ad0_log[4]), 64'h6800);
    chk("rd_ad7", 64'(ad0_log[7]), 64'h6800);
    chk("rd_ad8", 64'(ad0_log[8]), 64'h0);
    chk("rd_di5", 64'(di0_log[5]), 64'h005A00);
    CPU_RD = '0; DEV_DV = 1'b0; DEV_DO = '0;

    // Channel 1 held: TDM leaves a gap, compacting alternates 0/2.
    HOLD = 3'b010;
    do_reset(2);
    repeat (16) tick();
    chk("h1_tdm_ce3",  64'(ce0_log[3]),  64'h1);
    chk("h1_tdm_ce7",  64'(ce0_log[7]),  64'h0);
    chk("h1_tdm_ce11", 64'(ce0_log[11]), 64'h4);
    chk("h1_cmp_ce3",  64'(ce1_log[3]),  64'h1);
    chk("h1_cmp_ce7",  64'(ce1_log[7]),  64'h4);
    chk("h1_cmp_ce11", 64'(ce1_log[11]), 64'h1);
    chk("h1_cmp_ce15", 64'(ce1_log[15]), 64'h4);

    // All held, then channel 2 released.
    HOLD = 3'b111;
    do_reset(2);
    repeat (20) tick();
    HOLD = 3'b011;
    repeat (8) tick();
    ce_or = '0;
    for (int k = 0; k < 20; k++) ce_or = ce_or | ce1_log[k];
    chk("allheld_ce", 64'(ce_or), 64'h0);
    chk("release_ce23", 64'(ce1_log[23]), 64'h4);

    // Reset mid-slot aborts CPU1's slot.
    HOLD = '0;
    do_reset(2);
    acc_ce0 = '0; acc_ce1 = '0;
    repeat (6) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    repeat (4) tick();
    chk("midrst_tdm_acc", 64'(acc_ce0), 64'h1);
    chk("midrst_cmp_acc", 64'(acc_ce1), 64'h1);
    chk("midrst_ce3", 64'(ce0_log[3]), 64'h1);

    // Randomized traffic, hold patterns and occasional resets.
    for (int n = 0; n < 800; n++) begin
      CPU_AD = NCPU*AW'({$urandom, $urandom});
      CPU_DO = NCPU*DW'($urandom);
      CPU_RD = NCPU'($urandom);
      CPU_WR = NCPU'($urandom);
      DEV_DV = 1'($urandom);
      DEV_DO = DW'($urandom);
      if ($urandom_range(0, 5) == 0) HOLD = NCPU'($urandom_range(0, 7));
      RESET = ($urandom_range(0, 99) == 0);
      tick();
    end
    RESET = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
